// File: rtl/video_pattern_gen.sv
// Purpose : synthesizable raster source (do/de/hs/vs/fs) with selectable test patterns.
// Latency : en_i sampled high in IDLE at cycle N -> fs_o/hs_o fall at N+1, first de_o at N+max(P,1).
// Backpr. : none; free-running source, downstream must accept every de_o pixel.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   en_i          run enable, only looked at on frame boundaries
//   w_i, h_i      active pixels per line / active lines per frame (latched per frame)
//   pat_i         pattern: 0 = x, 1 = y, 2 = x+y+frame, 3 = 8x8 checker
//   do_o, de_o    pixel data / pixel valid (do_o holds while de_o=0)
//   hs_o, vs_o    line sync (0 during active line), frame sync (1 from first line start to last line end)
//   fs_o          one-cycle pulse on the first cycle of each frame
//   busy_o        1 whenever a frame is in progress
module video_pattern_gen #(
    parameter int DATA_WIDTH     = 8,
    parameter int LINE_SIZE_MAX  = 4096,
    parameter int LINE_COUNT_MAX = 4096,
    parameter int DE_I_PERIOD    = 0,
    parameter int H_BLANK        = 44,
    parameter int V_BLANK        = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    input  logic [$clog2(LINE_SIZE_MAX):0]    w_i,
    input  logic [$clog2(LINE_COUNT_MAX):0]   h_i,
    input  logic [1:0]                        pat_i,
    output logic [DATA_WIDTH-1:0]             do_o,
    output logic                              de_o,
    output logic                              hs_o,
    output logic                              vs_o,
    output logic                              fs_o,
    output logic                              busy_o
);

    localparam int XW   = $clog2(LINE_SIZE_MAX) + 1;
    localparam int YW   = $clog2(LINE_COUNT_MAX) + 1;
    // P=0 and P=1 both mean one pixel per clock; the slot counter then stays at 0.
    localparam int PE   = (DE_I_PERIOD < 2) ? 1 : DE_I_PERIOD;
    localparam int SW   = (PE < 3) ? 1 : $clog2(PE);
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX < 3) ? 1 : $clog2(BMAX);

    localparam logic [SW-1:0] SLOT_LAST = SW'(PE - 1);
    localparam logic [SW-1:0] SLOT_ONE  = SW'(1);
    localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST   = BW'(V_BLANK - 1);
    localparam logic [BW-1:0] B_ONE     = BW'(1);
    localparam logic [XW-1:0] X_ONE     = XW'(1);
    localparam logic [YW-1:0] Y_ONE     = YW'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

    state_t                 r_state, w_state;
    logic [XW-1:0]          r_x, w_x, r_w, w_w;
    logic [YW-1:0]          r_y, w_y, r_h, w_h;
    logic [SW-1:0]          r_slot, w_slot;
    logic [BW-1:0]          r_blank, w_blank;
    logic [1:0]             r_pat, w_pat;
    logic [7:0]             r_frame, w_frame;
    logic [DATA_WIDTH-1:0]  r_do, w_do;
    logic                   r_de, w_de, r_hs, w_hs, r_vs, w_vs, r_fs, w_fs, r_busy, w_busy;
    logic                   w_go, w_start;

    assign w_go = en_i && (w_i != '0) && (h_i != '0);

    // Next-state and counter update. The output registers are loaded from the
    // *next* counters so that every output is a plain flop.
    always_comb begin
        w_state = r_state;
        w_x     = r_x;
        w_y     = r_y;
        w_slot  = r_slot;
        w_blank = r_blank;
        w_w     = r_w;
        w_h     = r_h;
        w_pat   = r_pat;
        w_frame = r_frame;
        w_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_go;
            end
            S_ACTIVE: begin
                if (r_slot == SLOT_LAST) begin
                    if (r_x == r_w - X_ONE) begin
                        w_state = S_HBLANK;
                        w_blank = '0;
                    end else begin
                        w_x    = r_x + X_ONE;
                        w_slot = '0;
                    end
                end else begin
                    w_slot = r_slot + SLOT_ONE;
                end
            end
            S_HBLANK: begin
                if (r_blank == HB_LAST) begin
                    if (r_y == r_h - Y_ONE) begin
                        w_state = S_VBLANK;
                        w_blank = '0;
                    end else begin
                        w_state = S_ACTIVE;
                        w_x     = '0;
                        w_slot  = '0;
                        w_y     = r_y + Y_ONE;
                    end
                end else begin
                    w_blank = r_blank + B_ONE;
                end
            end
            S_VBLANK: begin
                if (r_blank == VB_LAST) begin
                    w_frame = r_frame + 8'd1;
                    w_start = w_go;
                    if (!w_go) begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_blank = r_blank + B_ONE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Frame boundary: configuration is captured only here.
        if (w_start) begin
            w_state = S_ACTIVE;
            w_x     = '0;
            w_y     = '0;
            w_slot  = '0;
            w_w     = w_i;
            w_h     = h_i;
            w_pat   = pat_i;
        end
    end

    always_comb begin
        w_fs   = w_start;
        w_busy = (w_state != S_IDLE);
        w_hs   = (w_state != S_ACTIVE);
        w_de   = (w_state == S_ACTIVE) && (w_slot == SLOT_LAST);
        // vs_o falls together with the hs_o rise that ends the last line.
        w_vs   = (w_state == S_ACTIVE) || ((w_state == S_HBLANK) && (w_y != w_h - Y_ONE));
        w_do   = r_do;
        if (w_de) begin
            case (w_pat)
                2'd0:    w_do = DATA_WIDTH'(w_x);
                2'd1:    w_do = DATA_WIDTH'(w_y);
                2'd2:    w_do = DATA_WIDTH'(w_x) + DATA_WIDTH'(w_y) + DATA_WIDTH'(w_frame);
                default: w_do = (w_x[3] ^ w_y[3]) ? {DATA_WIDTH{1'b1}} : '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_slot  <= '0;
            r_blank <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_pat   <= '0;
            r_frame <= '0;
            r_do    <= '0;
            r_de    <= 1'b0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b0;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_x     <= w_x;
            r_y     <= w_y;
            r_slot  <= w_slot;
            r_blank <= w_blank;
            r_w     <= w_w;
            r_h     <= w_h;
            r_pat   <= w_pat;
            r_frame <= w_frame;
            r_do    <= w_do;
            r_de    <= w_de;
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_fs    <= w_fs;
            r_busy  <= w_busy;
        end
    end

    assign do_o   = r_do;
    assign de_o   = r_de;
    assign hs_o   = r_hs;
    assign vs_o   = r_vs;
    assign fs_o   = r_fs;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: two instances (pixel period 0 and 4) share inputs.
// A frame-offset model predicts every output each cycle; directed phases pin
// frame geometry, pattern values, enable drop, mid-frame reconfig and reset.
module tb_video_pattern_gen;
    localparam int HB = 44;
    localparam int VB = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [12:0] w_in, h_in;
    logic [1:0]  pat_in;
    logic [7:0]  do_w [2];
    logic [1:0]  de_w, hs_w, vs_w, fs_w, busy_w;

    int checks = 0;
    int failures = 0;
    int cyc_prints = 0;

    always #5 clk = ~clk;

    video_pattern_gen #(.DE_I_PERIOD(0)) dut0 (
        .clk(clk), .rst(rst), .en_i(en), .w_i(w_in), .h_i(h_in), .pat_i(pat_in),
        .do_o(do_w[0]), .de_o(de_w[0]), .hs_o(hs_w[0]), .vs_o(vs_w[0]),
        .fs_o(fs_w[0]), .busy_o(busy_w[0]));

    video_pattern_gen #(.DE_I_PERIOD(4)) dut4 (
        .clk(clk), .rst(rst), .en_i(en), .w_i(w_in), .h_i(h_in), .pat_i(pat_in),
        .do_o(do_w[1]), .de_o(de_w[1]), .hs_o(hs_w[1]), .vs_o(vs_w[1]),
        .fs_o(fs_w[1]), .busy_o(busy_w[1]));

    // ---------------- model: position = offset t inside the current frame ----------------
    int pe_m [2] = '{1, 4};
    bit run_m [2];
    int t_m [2];
    int w_m [2];
    int h_m [2];
    int pat_m [2];
    int fr_m [2];
    int do_e [2];
    bit de_e [2];
    bit hs_e [2] = '{1'b1, 1'b1};
    bit vs_e [2];
    bit fs_e [2];
    bit busy_e [2];

    function automatic int pix(input int pat, input int x, input int y, input int fr);
        case (pat)
            0:       return x % 256;
            1:       return y % 256;
            2:       return (x + y + fr) % 256;
            default: return (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
        endcase
    endfunction

    function automatic void model_step(input int k);
        int ll, fl, y, r, x;
        if (rst) begin
            run_m[k] = 0; t_m[k] = 0; fr_m[k] = 0; do_e[k] = 0;
            de_e[k] = 0; hs_e[k] = 1; vs_e[k] = 0; fs_e[k] = 0; busy_e[k] = 0;
            return;
        end
        ll = w_m[k] * pe_m[k] + HB;
        fl = h_m[k] * ll + VB;
        if (!run_m[k] || t_m[k] == fl - 1) begin
            if (run_m[k]) fr_m[k] = (fr_m[k] + 1) % 256;
            if (en && w_in != 0 && h_in != 0) begin
                run_m[k] = 1; t_m[k] = 0;
                w_m[k] = int'(w_in); h_m[k] = int'(h_in); pat_m[k] = int'(pat_in);
            end else begin
                run_m[k] = 0;
            end
        end else begin
            t_m[k]++;
        end
        ll = w_m[k] * pe_m[k] + HB;
        de_e[k] = 0; fs_e[k] = 0; hs_e[k] = 1; vs_e[k] = 0; busy_e[k] = run_m[k];
        if (run_m[k]) begin
            fs_e[k] = (t_m[k] == 0);
            y = t_m[k] / ll;
            r = t_m[k] % ll;
            if (t_m[k] < h_m[k] * ll) begin
                if (r < w_m[k] * pe_m[k]) begin
                    hs_e[k] = 0;
                    vs_e[k] = 1;
                    if (r % pe_m[k] == pe_m[k] - 1) begin
                        x = r / pe_m[k];
                        de_e[k] = 1;
                        do_e[k] = pix(pat_m[k], x, y, fr_m[k]);
                    end
                end else begin
                    vs_e[k] = (y < h_m[k] - 1);
                end
            end
        end
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (do_w[k] !== 8'(do_e[k]) || de_w[k] !== de_e[k] || hs_w[k] !== hs_e[k] ||
                vs_w[k] !== vs_e[k] || fs_w[k] !== fs_e[k] || busy_w[k] !== busy_e[k]) begin
                failures++;
                if (cyc_prints < 10) begin
                    cyc_prints++;
                    $display("FAIL cyc_cmp dut%0d @%0t actual do=%0d de=%0b hs=%0b vs=%0b fs=%0b busy=%0b required do=%0d de=%0b hs=%0b vs=%0b fs=%0b busy=%0b",
                             k, $time, do_w[k], de_w[k], hs_w[k], vs_w[k], fs_w[k], busy_w[k],
                             do_e[k], de_e[k], hs_e[k], vs_e[k], fs_e[k], busy_e[k]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0] cap [2][16];
    int st_des [2];
    int st_vs [2];
    int st_hs0 [2];
    int st_first [2];
    int st_per [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_fs(input int k);
        int g;
        g = 0;
        while (!fs_w[k] && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("fs_wait", int'(fs_w[k]), 1);
    endtask

    // Measures one frame starting at its fs_o cycle; ends at the next fs_o or when busy_o drops.
    task automatic frame_stats(input int k);
        int n, des, vsn, hs0, first;
        bit hi;
        wait_fs(k);
        n = 0; des = 0; vsn = 0; hs0 = 0; first = -1; hi = 0;
        do begin
            if (de_w[k]) begin
                if (first < 0) first = n;
                if (des < 16) cap[k][des] = do_w[k];
                des++;
            end
            if (vs_w[k]) vsn++;
            if (hs_w[k]) hi = 1;
            else if (!hi) hs0++;
            @(negedge clk);
            n++;
        end while (!fs_w[k] && busy_w[k] && n < 20000);
        chk("frame_end", int'(n < 20000), 1);
        st_des[k] = des; st_vs[k] = vsn; st_hs0[k] = hs0; st_first[k] = first; st_per[k] = n;
    endtask

    task automatic chk_idle_outputs(input string nm, input int k);
        chk({nm, "_do"}, int'(do_w[k]), 0);
        chk({nm, "_de"}, int'(de_w[k]), 0);
        chk({nm, "_hs"}, int'(hs_w[k]), 1);
        chk({nm, "_vs"}, int'(vs_w[k]), 0);
        chk({nm, "_fs"}, int'(fs_w[k]), 0);
        chk({nm, "_busy"}, int'(busy_w[k]), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int g, cnt;
        rst = 1'b1; en = 1'b0; w_in = 13'd24; h_in = 13'd24; pat_in = 2'd0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) chk_idle_outputs("reset", k);

        // w=0 with enable: must stay idle
        rst = 1'b0; w_in = 13'd0; en = 1'b1;
        repeat (20) @(negedge clk);
        chk("w0_busy0", int'(busy_w[0]), 0);
        chk("w0_busy4", int'(busy_w[1]), 0);

        // 24x24 pattern 0, P=0 and P=4 in parallel
        w_in = 13'd24;
        fork
            frame_stats(0);
            frame_stats(1);
        join
        chk("p0_des", st_des[0], 576);   chk("p4_des", st_des[1], 576);
        chk("p0_hslow", st_hs0[0], 24);  chk("p4_hslow", st_hs0[1], 96);
        chk("p0_first", st_first[0], 0); chk("p4_first", st_first[1], 3);
        chk("p0_vs", st_vs[0], 1588);    chk("p4_vs", st_vs[1], 3316);
        chk("p0_period", st_per[0], 1646); chk("p4_period", st_per[1], 3374);
        chk("p0_x0", cap[0][0], 0);  chk("p0_x7", cap[0][7], 7);
        chk("p4_x0", cap[1][0], 0);  chk("p4_x15", cap[1][15], 15);

        // enable dropped at line 10: frame completes, then idle
        fork
            frame_stats(0);
            begin
                wait_fs(0);
                #6800 en = 1'b0;
            end
        join
        chk("drop_des", st_des[0], 576);
        chk("drop_period", st_per[0], 1646);
        chk("drop_hs", int'(hs_w[0]), 1);
        chk("drop_vs", int'(vs_w[0]), 0);
        chk("drop_busy", int'(busy_w[0]), 0);
        g = 0;
        while (busy_w[1] && g < 5000) begin @(negedge clk); g++; end
        chk("drop_busy4", int'(busy_w[1]), 0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (de_w != 2'b00) cnt++;
        end
        chk("drop_no_de", cnt, 0);

        // w changed mid-frame: current frame keeps 24, next has 8
        en = 1'b1;
        fork
            frame_stats(0);
            begin
                wait_fs(0);
                #3000 w_in = 13'd8;
            end
        join
        chk("wchg_des_old", st_des[0], 576);
        chk("wchg_per_old", st_per[0], 1646);
        frame_stats(0);
        chk("wchg_des_new", st_des[0], 192);
        chk("wchg_hslow_new", st_hs0[0], 8);
        chk("wchg_vs_new", st_vs[0], 1204);
        chk("wchg_per_new", st_per[0], 1262);

        // reset mid-line: outputs return to reset values without a clock edge
        w_in = 13'd4; h_in = 13'd2; pat_in = 2'd2;
        g = 0;
        while (!de_w[0] && g < 2000) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        chk("pre_rst_de", int'(de_w[0]), 1);
        #3 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk_idle_outputs("midrst", k);
        @(negedge clk);
        rst = 1'b0;

        // pattern 2 over a frame-counter wrap
        for (int f = 0; f <= 256; f++) begin
            frame_stats(0);
            if (f <= 2 || f >= 255) begin
                chk("p2_des", st_des[0], 8);
                chk("p2_period", st_per[0], 110);
                for (int i = 0; i < 8; i++) chk("p2_pix", int'(cap[0][i]), (f + i % 4 + i / 4) % 256);
            end
            if (f == 0) chk("p2_f0_l1x3", int'(cap[0][7]), 4);
            if (f == 1) chk("p2_f1_l1x0", int'(cap[0][4]), 2);
            if (f == 255) chk("p2_f255_x3", int'(cap[0][3]), 2);
            if (f == 256) chk("p2_wrap_x0", int'(cap[0][0]), 0);
        end

        // 1x1 frame
        w_in = 13'd1; h_in = 13'd1; pat_in = 2'd0;
        frame_stats(0);
        frame_stats(0);
        chk("one_des", st_des[0], 1);
        chk("one_vs", st_vs[0], 1);
        chk("one_hslow", st_hs0[0], 1);
        chk("one_period", st_per[0], 59);

        // checker pattern, 24x16
        w_in = 13'd24; h_in = 13'd16; pat_in = 2'd3;
        frame_stats(0);
        frame_stats(0);
        chk("chk_des", st_des[0], 384);
        chk("chk_period", st_per[0], 1102);
        chk("chk_x7", int'(cap[0][7]), 0);
        chk("chk_x8", int'(cap[0][8]), 255);

        en = 1'b0;
        g = 0;
        while (busy_w != 2'b00 && g < 6000) begin @(negedge clk); g++; end
        chk("end_idle", int'(busy_w), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
Synthesizable video source that produces a raster stream on the team's pixel interface (do/de/hs/vs). It sits directly upstream of filter_blur and other line-buffer filters, and replaces the behavioural bench driver for on-chip bring-up and regression. Frame size, pattern and per-pixel pacing are configurable, so downstream filters can be exercised without a camera front end.

Parameters:
DATA_WIDTH, 8, pixel width of do_o
LINE_SIZE_MAX, 4096, maximum active pixels per line; sets counter widths
LINE_COUNT_MAX, 4096, maximum active lines per frame
DE_I_PERIOD, 0, pixel cadence: 0 = one pixel every clk; P>=2 = one pixel every P clks, so P-1 empty cycles precede each pixel
H_BLANK, 44, cycles between lines (hs_o=1, de_o=0)
V_BLANK, 14, cycles between frames after the last line's H_BLANK

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en_i  in  1  run enable; sampled at frame boundaries
w_i  in  $clog2(LINE_SIZE_MAX)+1  active pixels per line
h_i  in  $clog2(LINE_COUNT_MAX)+1  active lines per frame
pat_i  in  2  pattern select
do_o  out  DATA_WIDTH  pixel data
de_o  out  1  pixel valid
hs_o  out  1  line sync; 0 during the active line, 1 during blanking
vs_o  out  1  frame sync; 1 from first line start until the last line ends
fs_o  out  1  one-cycle pulse on the first cycle of each frame
busy_o  out  1  1 whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: do_o=0, de_o=0, hs_o=1, vs_o=0, fs_o=0, busy_o=0. State returns to IDLE; x, y, slot and frame counters clear to 0.
- Reset asserted mid-frame forces the reset values immediately (async). No partial line completes.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - Exit when en_i=1 and w_i>=1 and h_i>=1. w_i, h_i and pat_i are latched on that cycle.
  - Next cycle: state ACTIVE, hs_o=0, vs_o=1, fs_o=1.
  - If w_i=0 or h_i=0, stay in IDLE.
- ACTIVE:
  - hs_o=0, vs_o=1.
  - DE_I_PERIOD=0: de_o=1 on every cycle, x increments 0..w-1.
  - DE_I_PERIOD=P>=2: a slot counter runs 0..P-1. de_o=1 only at slot P-1, and x increments on that cycle. The first pixel of a line appears P-1 cycles after line start.
  - do_o is valid only while de_o=1. When de_o=0, do_o holds its last value.
  - After pixel x=w-1, the next cycle enters HBLANK.
- HBLANK:
  - Lasts H_BLANK cycles, with hs_o=1 and de_o=0.
  - If y<h-1: vs_o stays 1, y increments, then the next state is ACTIVE.
  - If y=h-1: vs_o drops to 0 on the same cycle hs_o rises, then the next state is VBLANK.
- VBLANK:
  - Lasts V_BLANK cycles, with vs_o=0, hs_o=1, de_o=0.
  - The frame counter (8 bit, wraps 255->0) increments.
  - On the last cycle, the IDLE exit rule is re-evaluated: new config is latched, and the next state is ACTIVE with fs_o=1, or IDLE.
- en_i dropping mid-frame has no effect until the end of VBLANK. The frame always completes.
- Changes to w_i, h_i or pat_i mid-frame are ignored until the next frame-boundary latch.
- Patterns (x, y are pixel coordinates; arithmetic is modulo 2^DATA_WIDTH):
  - 0: do = x[DATA_WIDTH-1:0]
  - 1: do = y[DATA_WIDTH-1:0]
  - 2: do = x + y + frame_cnt, truncated
  - 3: checker 8x8: do = all-ones if x[3]^y[3], else 0
- Latency: en_i sampled high in IDLE at cycle N gives:
  - hs_o falling and fs_o at cycle N+1
  - first de_o at N+1 (P=0) or N+P (P>=2)
- Cycles per line: w*max(P,1) + H_BLANK.
- Cycles per frame: h*(w*max(P,1) + H_BLANK) + V_BLANK.
- Boundary sizes:
  - w=1: one de per line.
  - h=1: vs_o falls after the first line.
  - w=LINE_SIZE_MAX: x reaches LINE_SIZE_MAX-1 without overflow.

Test Plan:
- w=24, h=24, pat=0, P=0, en=1 -> 24 de pulses per line with do=0..23. hs_o low for exactly 24 cycles. vs_o falls with the 24th hs_o rise. fs_o pulses once per frame. Period = 24*(24+44)+14 = 1646 cycles.
- Same setup with P=4 -> de_o every 4th cycle, first de_o 3 cycles after hs_o falls. hs_o low for 96 cycles per line. Data identical to P=0.
- pat=2, w=4, h=2, three frames -> line0 of frame f = f, f+1, f+2, f+3; line1 shifted +1. After 256 frames the frame term wraps to 0.
- en_i dropped at line 10 of a frame -> frame completes all 24 lines and VBLANK, then busy_o=0, hs_o=1, vs_o=0. No further de_o.
- w_i changed 24->8 mid-frame -> current frame keeps 24 pixels/line; next frame has 8.
- rst pulsed mid-line -> same cycle de_o=0, hs_o=1, vs_o=0, do_o=0. After release with en=1, a fresh frame starts at x=0, y=0, frame_cnt=0. w_i=0 with en=1 -> stays IDLE, busy_o=0.
